// File: rtl/crossbar_pkg.sv
// Shared crossbar definitions: port geometry, FSM encoding, lane slicing and
// round-robin search helpers.
package crossbar_pkg;

  localparam int unsigned NPORTS   = 16;
  localparam int unsigned SEL_W    = 4;
  localparam int unsigned LANE_MAX = 64;
  localparam int unsigned BUS_AW   = $clog2(NPORTS * LANE_MAX);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    GRANT = ST_GRANT,
    WAIT  = ST_WAIT
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } rr_pick_t;

  // Bit b of lane 'lane' from a flat bus zero-extended to LANE_MAX-bit lanes.
  function automatic logic lane_bit(input logic [NPORTS*LANE_MAX-1:0] bus,
                                    input int unsigned lane_w,
                                    input logic [SEL_W-1:0] lane,
                                    input int unsigned b);
    logic [BUS_AW-1:0] pos;
    pos = BUS_AW'(32'(lane) * lane_w + b);
    return bus[pos];
  endfunction

  function automatic rr_pick_t rr_first(input logic [NPORTS-1:0] v,
                                        input logic [SEL_W-1:0] start);
    rr_pick_t         p;
    logic [SEL_W-1:0] k4;
    p = '0;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      k4 = start + SEL_W'(k);
      if (!p.found && v[k4]) begin
        p.found = 1'b1;
        p.idx   = k4;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/crossbar_output_port_if.sv
// Request/grant and drain signals between one output port, the input queues
// and the downstream consumer.
interface crossbar_output_port_if #(
  parameter int unsigned WIDTH = 8
);
  import crossbar_pkg::*;

  logic [NPORTS-1:0]         req_valid;
  logic [NPORTS*SEL_W-1:0]   req_sel;
  logic [NPORTS*(WIDTH+1)-1:0] in_bus;
  logic [NPORTS-1:0]         grant;
  logic [WIDTH-1:0]          out_data;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output req_valid, req_sel, in_bus, out_ready,
    input  grant, out_data, out_valid
  );

  modport slave (
    input  req_valid, req_sel, in_bus, out_ready,
    output grant, out_data, out_valid
  );

endinterface

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with synchronous active-high reset; head entry is read
// straight from the storage registers.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_valid,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;
  assign w_push  = i_push && !o_full && !rst;
  assign w_pop   = i_pop && o_valid;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/crossbar_output_port.sv
// Output-side crossbar endpoint: round-robin arbitration over the 16 input
// queues, one-cycle grant, lane capture with timeout, and an output FIFO.
module crossbar_output_port
  import crossbar_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [SEL_W-1:0]           id,
  crossbar_output_port_if.slave      bus,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic [7:0]                 drop_count,
  output logic                       busy
);

  localparam int unsigned LW = WIDTH + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_t                    r_state;
  logic [NPORTS-1:0]         r_grant;
  logic [SEL_W-1:0]          r_rr;
  logic [SEL_W-1:0]          r_winner;
  logic [TW-1:0]             r_timer;
  logic [7:0]                r_drop;

  logic [NPORTS-1:0]         w_req;
  rr_pick_t                  w_pick;
  logic [NPORTS*LANE_MAX-1:0] w_bus_ext;
  logic [LW-1:0]             w_lane;
  logic                      w_push;
  logic                      w_full;

  genvar g;
  generate
    for (g = 0; g < NPORTS; g++) begin : g_req
      assign w_req[g] = bus.req_valid[g] && (bus.req_sel[g*SEL_W +: SEL_W] == id);
    end
    for (g = 0; g < LW; g++) begin : g_lane
      assign w_lane[g] = lane_bit(w_bus_ext, LW, r_winner, g);
    end
  endgenerate

  assign w_bus_ext  = {{(NPORTS*(LANE_MAX-LW)){1'b0}}, bus.in_bus};
  assign w_pick     = rr_first(w_req, r_rr);
  assign w_push     = (r_state == WAIT) && w_lane[WIDTH];
  assign bus.grant  = r_grant;
  assign drop_count = r_drop;
  assign busy       = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_rr     <= '0;
      r_winner <= '0;
      r_timer  <= '0;
      r_drop   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick.found && !w_full) begin
            r_grant  <= {{(NPORTS-1){1'b0}}, 1'b1} << w_pick.idx;
            r_winner <= w_pick.idx;
            r_state  <= GRANT;
          end
        end
        GRANT: begin
          r_grant <= '0;
          r_timer <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          r_timer <= r_timer + 1'b1;
          if (w_lane[WIDTH]) begin
            r_rr    <= r_winner + 1'b1;
            r_state <= IDLE;
          end else if (r_timer + 1'b1 == TW'(TIMEOUT)) begin
            if (r_drop != 8'hFF) r_drop <= r_drop + 1'b1;
            r_rr    <= r_winner + 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          r_grant <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_lane[WIDTH-1:0]),
    .i_pop   (bus.out_ready),
    .o_data  (bus.out_data),
    .o_valid (bus.out_valid),
    .o_full  (w_full),
    .o_count (fifo_count)
  );

endmodule

// File: tb/tb_crossbar_output_port.sv
// Directed bench for crossbar_output_port (DEPTH=4, TIMEOUT=3, id=5).
module tb_crossbar_output_port;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id;
  logic [2:0] fifo_count;
  logic [7:0] drop_count;
  logic       busy;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  crossbar_output_port_if #(.WIDTH(8)) bus ();

  crossbar_output_port #(
    .WIDTH   (8),
    .DEPTH   (4),
    .TIMEOUT (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .id         (id),
    .bus        (bus),
    .fifo_count (fifo_count),
    .drop_count (drop_count),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int q, input logic v, input logic [3:0] sel);
    bus.req_valid[q]      = v;
    bus.req_sel[q*4 +: 4] = sel;
  endtask

  task automatic set_lane(input int q, input logic v, input logic [7:0] d);
    bus.in_bus[q*9 +: 9] = {v, d};
  endtask

  // Wait (bounded) for a grant, check it, then answer on lane q during WAIT.
  task automatic do_txn(input string tag, input int q, input logic [15:0] exp_g,
                        input logic [7:0] d);
    for (int n = 0; n < 20; n++) begin
      step();
      if (bus.grant != '0) break;
    end
    chk(tag, 32'(bus.grant), 32'(exp_g));
    step();
    set_lane(q, 1'b1, d);
    step();
    set_lane(q, 1'b0, 8'h00);
  endtask

  initial begin
    rst           = 1'b1;
    id            = 4'd0;
    bus.req_valid = '0;
    bus.req_sel   = '0;
    bus.in_bus    = '0;
    bus.out_ready = 1'b0;

    // reset while every input toggles
    for (int n = 0; n < 6; n++) begin
      step();
      bus.req_valid = 16'($urandom);
      bus.req_sel   = 64'({$urandom, $urandom});
      bus.in_bus    = 144'({$urandom, $urandom, $urandom, $urandom, $urandom});
      id            = 4'($urandom);
      bus.out_ready = 1'($urandom);
    end
    chk("rst grant", 32'(bus.grant), 32'h0);
    chk("rst out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst fifo_count", 32'(fifo_count), 32'h0);
    chk("rst drop_count", 32'(drop_count), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);

    bus.req_valid = '0;
    bus.req_sel   = '0;
    bus.in_bus    = '0;
    bus.out_ready = 1'b0;
    id            = 4'd5;
    step();
    rst = 1'b0;

    // single transfer from queue 3
    set_req(3, 1'b1, 4'd5);
    step();
    chk("q3 grant", 32'(bus.grant), 32'h0008);
    chk("q3 busy", 32'(busy), 32'h1);
    set_req(3, 1'b0, 4'd0);
    step();
    chk("q3 grant drop", 32'(bus.grant), 32'h0);
    chk("q3 wait busy", 32'(busy), 32'h1);
    set_lane(3, 1'b1, 8'hA5);
    step();
    set_lane(3, 1'b0, 8'h00);
    chk("q3 out_valid", 32'(bus.out_valid), 32'h1);
    chk("q3 out_data", 32'(bus.out_data), 32'hA5);
    chk("q3 fifo_count", 32'(fifo_count), 32'h1);
    chk("q3 idle", 32'(busy), 32'h0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("q3 drained", 32'(fifo_count), 32'h0);

    // round robin over queues 0, 7, 15 from rr_ptr=0
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    set_req(0, 1'b1, 4'd5);
    set_req(7, 1'b1, 4'd5);
    set_req(15, 1'b1, 4'd5);
    do_txn("rr g0", 0, 16'h0001, 8'h01);
    do_txn("rr g1", 7, 16'h0080, 8'h02);
    do_txn("rr g2", 15, 16'h8000, 8'h03);
    do_txn("rr g3", 0, 16'h0001, 8'h04);
    set_req(0, 1'b0, 4'd0);
    set_req(7, 1'b0, 4'd0);
    set_req(15, 1'b0, 4'd0);
    step();
    step();
    chk("rr drained", 32'(fifo_count), 32'h0);

    // request addressed to another port
    set_req(2, 1'b1, 4'd4);
    for (int n = 0; n < 3; n++) begin
      step();
      chk("other grant", 32'(bus.grant), 32'h0);
      chk("other busy", 32'(busy), 32'h0);
    end
    set_req(2, 1'b0, 4'd0);

    // timeout on queue 9; queue 1 must win next (rr_ptr=10)
    set_req(9, 1'b1, 4'd5);
    step();
    chk("q9 grant", 32'(bus.grant), 32'h0200);
    set_req(1, 1'b1, 4'd5);
    set_lane(3, 1'b1, 8'h3C);
    step();
    step();
    step();
    chk("q9 pre-timeout drop", 32'(drop_count), 32'h0);
    chk("q9 pre-timeout busy", 32'(busy), 32'h1);
    step();
    chk("q9 drop_count", 32'(drop_count), 32'h1);
    chk("q9 idle", 32'(busy), 32'h0);
    chk("q9 no push", 32'(fifo_count), 32'h0);
    step();
    chk("q1 grant", 32'(bus.grant), 32'h0002);
    set_req(9, 1'b0, 4'd0);
    set_req(1, 1'b0, 4'd0);
    set_lane(3, 1'b0, 8'h00);
    step();
    set_lane(1, 1'b1, 8'h77);
    step();
    set_lane(1, 1'b0, 8'h00);
    chk("q1 out_valid", 32'(bus.out_valid), 32'h1);
    chk("q1 out_data", 32'(bus.out_data), 32'h77);
    step();
    chk("q1 drained", 32'(fifo_count), 32'h0);

    // fill the FIFO, stall arbitration, then reset mid-WAIT
    bus.out_ready = 1'b0;
    set_req(4, 1'b1, 4'd5);
    for (int k = 0; k < 4; k++) do_txn("fill grant", 4, 16'h0010, 8'(16 + k));
    chk("full count", 32'(fifo_count), 32'h4);
    chk("full head", 32'(bus.out_data), 32'h10);
    for (int n = 0; n < 3; n++) begin
      step();
      chk("full no grant", 32'(bus.grant), 32'h0);
      chk("full busy", 32'(busy), 32'h0);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("pop count", 32'(fifo_count), 32'h3);
    chk("pop head", 32'(bus.out_data), 32'h11);
    chk("pop same-cycle grant", 32'(bus.grant), 32'h0);
    step();
    chk("space grant", 32'(bus.grant), 32'h0010);
    set_req(4, 1'b0, 4'd0);
    step();
    set_lane(4, 1'b1, 8'hEE);
    rst = 1'b1;
    step();
    chk("abort count", 32'(fifo_count), 32'h0);
    chk("abort out_valid", 32'(bus.out_valid), 32'h0);
    chk("abort busy", 32'(busy), 32'h0);
    chk("abort grant", 32'(bus.grant), 32'h0);
    chk("abort drop_count", 32'(drop_count), 32'h0);
    rst = 1'b0;
    step();
    chk("late valid ignored", 32'(fifo_count), 32'h0);
    chk("late valid busy", 32'(busy), 32'h0);
    set_lane(4, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crossbar_output_port.md
Name: crossbar_output_port

Overview:
- Output-side endpoint of the 16x16 crossbar; one instance per output port.
- Watches the head-of-line requests of all 16 input queues and arbitrates round-robin among those addressed to this port.
- Issues the one-hot grant back to the queues, captures the granted lane's {valid,data} word and buffers it in a local FIFO with a ready/valid drain interface.

Parameters:
- WIDTH, 8, payload bits per word (lane word is WIDTH+1: MSB is the valid bit).
- DEPTH, 8, output FIFO entries; power of two, at least 2.
- TIMEOUT, 3, number of WAIT cycles without lane valid before the grant is abandoned.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- id  in  4  index of this output port; static after reset.
- req_valid  in  16  bit i: input queue i holds a word (its ptr is nonzero).
- req_sel  in  64  bits [4i+3:4i]: destination select of queue i's head word.
- in_bus  in  16*(WIDTH+1)  lane i at [(i+1)*(WIDTH+1)-1 : i*(WIDTH+1)]; MSB is valid, low WIDTH bits are data.
- grant  out  16  one-hot grant to the input queues; bit i drives queue i's grant vector for this port.
- out_data  out  WIDTH  FIFO head word.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  downstream accepts out_data.
- fifo_count  out  $clog2(DEPTH+1)  current occupancy.
- drop_count  out  8  saturating count of abandoned grants.
- busy  out  1  FSM state is not IDLE.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - grant=0, FIFO emptied (out_valid=0, fifo_count=0), drop_count=0, busy=0.
  - rr_ptr=0, state=IDLE, timer=0.
  - A reset in any state aborts the transaction immediately; a partial transfer is not recorded.
- Request vector: r[i] = req_valid[i] && (req_sel[4i+3:4i] == id).
- FSM states:
  - IDLE:
    - If r != 0 and fifo_count < DEPTH: winner = first set bit of r scanning from rr_ptr upward, mod 16.
    - Register grant = onehot(winner) and go to GRANT.
    - Otherwise grant stays 0.
  - GRANT:
    - grant is held high for exactly this one cycle.
    - Next cycle: grant=0, timer=0, go to WAIT.
  - WAIT:
    - If the MSB of lane[winner] is 1: push the lane's low WIDTH bits into the FIFO, set rr_ptr = winner+1 (4-bit wrap), go to IDLE.
    - Else timer++. When timer reaches TIMEOUT: drop_count++ (saturates at 255), rr_ptr = winner+1, go to IDLE.
    - Valid MSBs on non-winner lanes are ignored in every state.
- Grant latency: the first grant is visible 1 cycle after the requesting inputs are sampled in IDLE. A minimum transaction is IDLE->GRANT->WAIT->IDLE, 3 cycles.
- Back-to-back: IDLE may grant again the cycle after returning from WAIT.
- FIFO:
  - Circular buffer; out_data is the registered head entry.
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle are both legal; count is unchanged.
  - Space is checked at grant time and there is at most one push per transaction, so overflow cannot occur.
  - Pop on empty is ignored.
- Occupancy: fifo_count = pushes - pops, range 0..DEPTH.
- Changes to id are only supported while in reset.

Decomposition:
- Shared package crossbar_pkg holds:
  - NPORTS=16 and SEL_W=4.
  - A lane-slicing function (lane i from the flat bus).
  - A round-robin first-set function (vector, start index -> index and found flag).
  - The FSM state enum (IDLE, GRANT, WAIT).
- Sub-module sync_fifo (WIDTH, DEPTH, synchronous active-high reset), instantiated once for the output buffer.

Test Plan:
- Reset with all inputs toggling -> grant=0, out_valid=0, fifo_count=0, drop_count=0, busy=0.
- id=5; queue 3 has req_valid=1, sel=5 -> grant=16'h0008 for one cycle. Drive lane3={1,8'hA5} on the next cycle -> out_valid=1, out_data=8'hA5, fifo_count=1, FSM back in IDLE.
- Queues 0, 7 and 15 request continuously with sel=id, and each replies when granted -> grant sequence 0x0001, 0x0080, 0x8000, 0x0001.
- Queue 2 requests with sel=4 while id=5 -> grant stays 0 and busy stays 0.
- Queue 9 is granted but lane9 MSB stays 0 for 3 WAIT cycles -> drop_count=1, FSM to IDLE, rr_ptr=10. A concurrent queue 1 request is granted next.
- DEPTH=4, out_ready=0, 4 completed transfers -> fifo_count=4 and no grant while full. Raise out_ready for one cycle -> count 3, a grant is issued. Assert rst during the following WAIT -> all state cleared, and the late lane valid is not pushed.
